// File: rtl/display_timing_cfg.sv
// Runtime-configurable sync/DE/strobe generator; look-ahead pre_x/pre_y lead the decoded outputs by LOOKAHEAD cycles.
// New modes are taken over valid/ready and applied only on the last pixel of a frame (cfg_ready low while pending).
module display_timing_cfg #(
  parameter int CORDW     = 16,
  parameter int LOOKAHEAD = 2,
  parameter int DEF_H_RES  = 640,
  parameter int DEF_H_FP   = 16,
  parameter int DEF_H_SYNC = 96,
  parameter int DEF_H_BP   = 48,
  parameter int DEF_V_RES  = 480,
  parameter int DEF_V_FP   = 10,
  parameter int DEF_V_SYNC = 2,
  parameter int DEF_V_BP   = 33,
  parameter bit DEF_H_POL  = 1'b0,
  parameter bit DEF_V_POL  = 1'b0
) (
  input  logic                    clk_pix,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CORDW-2:0]        cfg_h_res,
  input  logic [CORDW-2:0]        cfg_h_fp,
  input  logic [CORDW-2:0]        cfg_h_sync,
  input  logic [CORDW-2:0]        cfg_h_bp,
  input  logic [CORDW-2:0]        cfg_v_res,
  input  logic [CORDW-2:0]        cfg_v_fp,
  input  logic [CORDW-2:0]        cfg_v_sync,
  input  logic [CORDW-2:0]        cfg_v_bp,
  input  logic                    cfg_h_pol,
  input  logic                    cfg_v_pol,
  output logic                    cfg_err,
  output logic                    mode_applied,
  output logic signed [CORDW-1:0] pre_x,
  output logic signed [CORDW-1:0] pre_y,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic signed [CORDW-1:0] screen_x,
  output logic signed [CORDW-1:0] screen_y
);

  localparam logic signed [CORDW-1:0] DEF_H_STA  = CORDW'(-(DEF_H_FP + DEF_H_SYNC + DEF_H_BP));
  localparam logic signed [CORDW-1:0] DEF_HS_STA = CORDW'(-(DEF_H_SYNC + DEF_H_BP));
  localparam logic signed [CORDW-1:0] DEF_HS_END = CORDW'(-DEF_H_BP);
  localparam logic signed [CORDW-1:0] DEF_HA_END = CORDW'(DEF_H_RES - 1);
  localparam logic signed [CORDW-1:0] DEF_V_STA  = CORDW'(-(DEF_V_FP + DEF_V_SYNC + DEF_V_BP));
  localparam logic signed [CORDW-1:0] DEF_VS_STA = CORDW'(-(DEF_V_SYNC + DEF_V_BP));
  localparam logic signed [CORDW-1:0] DEF_VS_END = CORDW'(-DEF_V_BP);
  localparam logic signed [CORDW-1:0] DEF_VA_END = CORDW'(DEF_V_RES - 1);
  localparam logic signed [CORDW-1:0] ONE_C = 1;
  localparam logic signed [CORDW:0]   ONE_W = 1;

  typedef enum logic {IDLE, PENDING} state_t;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             frame;
    logic             line;
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
  } tim_t;

  localparam tim_t TIM_RST = '{hsync: ~DEF_H_POL, vsync: ~DEF_V_POL, de: 1'b0, frame: 1'b0,
                               line: 1'b0, sx: DEF_H_STA, sy: DEF_V_STA};

  state_t state, state_nxt;

  logic signed [CORDW-1:0] h_sta, hs_sta, hs_end, ha_end;
  logic signed [CORDW-1:0] v_sta, vs_sta, vs_end, va_end;
  logic                    h_pol, v_pol;

  logic [CORDW-2:0] sh_h_res, sh_h_fp, sh_h_sync, sh_h_bp;
  logic [CORDW-2:0] sh_v_res, sh_v_fp, sh_v_sync, sh_v_bp;
  logic             sh_h_pol, sh_v_pol;

  logic signed [CORDW:0] nh_sta, nh_hs_sta, nh_hs_end, nh_a_end;
  logic signed [CORDW:0] nv_sta, nv_vs_sta, nv_vs_end, nv_a_end;

  logic signed [CORDW-1:0] x, y, x_nxt, y_nxt;
  logic cfg_fire, cfg_ok, last_pix, apply;
  logic hs_act, vs_act;
  tim_t dec;
  tim_t pipe [LOOKAHEAD];

  assign cfg_fire = cfg_valid && cfg_ready;
  assign cfg_ok   = (cfg_h_res != '0) && (cfg_v_res != '0) && (cfg_h_sync != '0) && (cfg_v_sync != '0);
  assign last_pix = (x == ha_end) && (y == va_end);
  assign apply    = (state == PENDING) && last_pix;

  // Handshake FSM: state register, next-state, outputs
  always_ff @(posedge clk_pix) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_fire && cfg_ok) state_nxt = PENDING;
      PENDING: if (apply) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE);
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sh_h_res  <= '0;
      sh_h_fp   <= '0;
      sh_h_sync <= '0;
      sh_h_bp   <= '0;
      sh_v_res  <= '0;
      sh_v_fp   <= '0;
      sh_v_sync <= '0;
      sh_v_bp   <= '0;
      sh_h_pol  <= 1'b0;
      sh_v_pol  <= 1'b0;
    end else if (cfg_fire && cfg_ok) begin
      sh_h_res  <= cfg_h_res;
      sh_h_fp   <= cfg_h_fp;
      sh_h_sync <= cfg_h_sync;
      sh_h_bp   <= cfg_h_bp;
      sh_v_res  <= cfg_v_res;
      sh_v_fp   <= cfg_v_fp;
      sh_v_sync <= cfg_v_sync;
      sh_v_bp   <= cfg_v_bp;
      sh_h_pol  <= cfg_h_pol;
      sh_v_pol  <= cfg_v_pol;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      cfg_err      <= 1'b0;
      mode_applied <= 1'b0;
    end else begin
      cfg_err      <= cfg_fire && !cfg_ok;
      mode_applied <= apply;
    end
  end

  // Shadow limits are one bit wider so the sums cannot wrap before truncation
  assign nh_sta    = -($signed({2'b00, sh_h_fp}) + $signed({2'b00, sh_h_sync}) + $signed({2'b00, sh_h_bp}));
  assign nh_hs_sta = nh_sta + $signed({2'b00, sh_h_fp});
  assign nh_hs_end = nh_hs_sta + $signed({2'b00, sh_h_sync});
  assign nh_a_end  = $signed({2'b00, sh_h_res}) - ONE_W;
  assign nv_sta    = -($signed({2'b00, sh_v_fp}) + $signed({2'b00, sh_v_sync}) + $signed({2'b00, sh_v_bp}));
  assign nv_vs_sta = nv_sta + $signed({2'b00, sh_v_fp});
  assign nv_vs_end = nv_vs_sta + $signed({2'b00, sh_v_sync});
  assign nv_a_end  = $signed({2'b00, sh_v_res}) - ONE_W;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      h_sta  <= DEF_H_STA;
      hs_sta <= DEF_HS_STA;
      hs_end <= DEF_HS_END;
      ha_end <= DEF_HA_END;
      v_sta  <= DEF_V_STA;
      vs_sta <= DEF_VS_STA;
      vs_end <= DEF_VS_END;
      va_end <= DEF_VA_END;
      h_pol  <= DEF_H_POL;
      v_pol  <= DEF_V_POL;
    end else if (apply) begin
      h_sta  <= nh_sta[CORDW-1:0];
      hs_sta <= nh_hs_sta[CORDW-1:0];
      hs_end <= nh_hs_end[CORDW-1:0];
      ha_end <= nh_a_end[CORDW-1:0];
      v_sta  <= nv_sta[CORDW-1:0];
      vs_sta <= nv_vs_sta[CORDW-1:0];
      vs_end <= nv_vs_end[CORDW-1:0];
      va_end <= nv_a_end[CORDW-1:0];
      h_pol  <= sh_h_pol;
      v_pol  <= sh_v_pol;
    end
  end

  always_comb begin
    x_nxt = x + ONE_C;
    y_nxt = y;
    if (apply) begin
      x_nxt = nh_sta[CORDW-1:0];
      y_nxt = nv_sta[CORDW-1:0];
    end else if (x == ha_end) begin
      x_nxt = h_sta;
      y_nxt = (y == va_end) ? v_sta : y + ONE_C;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      x <= DEF_H_STA;
      y <= DEF_V_STA;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

  assign pre_x = x;
  assign pre_y = y;

  // Decode uses the live limits, which change on the same edge as the counter
  assign hs_act = (x >= hs_sta) && (x < hs_end);
  assign vs_act = (y >= vs_sta) && (y < vs_end);

  always_comb begin
    dec       = TIM_RST;
    dec.hsync = h_pol ? hs_act : !hs_act;
    dec.vsync = v_pol ? vs_act : !vs_act;
    dec.de    = !x[CORDW-1] && !y[CORDW-1];
    dec.frame = (x == h_sta) && (y == v_sta);
    dec.line  = (x == h_sta) && !y[CORDW-1];
    dec.sx    = x;
    dec.sy    = y;
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      for (int i = 0; i < LOOKAHEAD; i++) pipe[i] <= TIM_RST;
    end else begin
      pipe[0] <= dec;
      for (int i = 1; i < LOOKAHEAD; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign hsync    = pipe[LOOKAHEAD-1].hsync;
  assign vsync    = pipe[LOOKAHEAD-1].vsync;
  assign de       = pipe[LOOKAHEAD-1].de;
  assign frame    = pipe[LOOKAHEAD-1].frame;
  assign line     = pipe[LOOKAHEAD-1].line;
  assign screen_x = pipe[LOOKAHEAD-1].sx;
  assign screen_y = pipe[LOOKAHEAD-1].sy;

endmodule

// File: tb/tb_display_timing_cfg.sv
// Bench for display_timing_cfg using small modes; per-frame measurements, apply pulses and error pulses
// are checked by a monitor against expectations queued by the stimulus.
module tb_display_timing_cfg;

  localparam int CORDW = 16;
  localparam int LA    = 3;

  logic clk_pix = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready, cfg_err, mode_applied;
  logic [CORDW-2:0] cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [CORDW-2:0] cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic cfg_h_pol, cfg_v_pol;
  logic signed [CORDW-1:0] pre_x, pre_y, screen_x, screen_y;
  logic hsync, vsync, de, frame, line;

  display_timing_cfg #(
    .CORDW(CORDW), .LOOKAHEAD(LA),
    .DEF_H_RES(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(2),
    .DEF_V_RES(4), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(1),
    .DEF_H_POL(1'b0), .DEF_V_POL(1'b0)
  ) dut (
    .clk_pix(clk_pix), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_res(cfg_h_res), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_res(cfg_v_res), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
    .cfg_err(cfg_err), .mode_applied(mode_applied),
    .pre_x(pre_x), .pre_y(pre_y),
    .hsync(hsync), .vsync(vsync), .de(de), .frame(frame), .line(line),
    .screen_x(screen_x), .screen_y(screen_y)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {int hr, hf, hs, hb, vr, vf, vs, vb; bit hp, vp;} cfg_t;
  typedef struct {int period, de_n, hs_hi, vs_hi, lines;} fexp_t;
  typedef struct {int x, y;} aexp_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  fexp_t fq[$];
  aexp_t aq[$];
  int    eq[$];
  int    alq[$];
  bit    align_on = 1'b0;
  int    applied_cyc = -1;

  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cfg_t mk(int hr, hf, hs, hb, vr, vf, vs, vb, bit hp, vp);
    cfg_t c;
    c.hr = hr; c.hf = hf; c.hs = hs; c.hb = hb;
    c.vr = vr; c.vf = vf; c.vs = vs; c.vb = vb;
    c.hp = hp; c.vp = vp;
    return c;
  endfunction

  function automatic fexp_t fr(int p, d, h, v, l);
    fexp_t f;
    f.period = p; f.de_n = d; f.hs_hi = h; f.vs_hi = v; f.lines = l;
    return f;
  endfunction

  function automatic aexp_t ap(int x, y);
    aexp_t a;
    a.x = x; a.y = y;
    return a;
  endfunction

  // Hand-computed per-frame figures: period, de cycles, hsync-high cycles, vsync-high cycles, line pulses
  fexp_t FA, FB, FC;
  cfg_t  MB, MC, MD;
  initial begin
    FA = fr(120, 32, 96, 90, 4);  // 15x8, neg/neg
    FB = fr(84, 18, 14, 12, 3);   // 12x7, pos/pos
    FC = fr(35, 8, 5, 28, 2);     // 7x5, pos/neg
    MB = mk(6, 1, 2, 3, 3, 2, 1, 1, 1'b1, 1'b1);
    MC = mk(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0);
    MD = mk(4, 1, 0, 1, 2, 1, 1, 1, 1'b1, 1'b0);
  end

  // Monitor
  bit have = 1'b0;
  int c_per, c_de, c_hs, c_vs, c_ln;
  int line_cyc = 0;
  bit prev_de, prev_hs, prev_vs;

  always @(negedge clk_pix) begin
    if (rst) begin
      have = 1'b0;
      c_per = 0; c_de = 0; c_hs = 0; c_vs = 0; c_ln = 0;
      prev_de = de; prev_hs = hsync; prev_vs = vsync;
    end else begin
      if (frame) begin
        if (have && fq.size() > 0) begin
          fexp_t e;
          e = fq.pop_front();
          chk("frame_period", c_per, e.period);
          chk("frame_de_count", c_de, e.de_n);
          chk("frame_hsync_high", c_hs, e.hs_hi);
          chk("frame_vsync_high", c_vs, e.vs_hi);
          chk("frame_line_pulses", c_ln, e.lines);
        end
        have = 1'b1;
        c_per = 0; c_de = 0; c_hs = 0; c_vs = 0; c_ln = 0;
      end
      c_per++;
      if (de) c_de++;
      if (hsync) c_hs++;
      if (vsync) c_vs++;
      if (line) begin
        c_ln++;
        line_cyc = cyc;
      end
      if (mode_applied) begin
        applied_cyc = cyc;
        if (aq.size() > 0) begin
          aexp_t a;
          a = aq.pop_front();
          chk("apply_pre_x", int'(pre_x), a.x);
          chk("apply_pre_y", int'(pre_y), a.y);
          chk("apply_cfg_ready", int'(cfg_ready), 1);
        end else begin
          chk("unexpected_mode_applied", int'(mode_applied), 0);
        end
      end
      if (cfg_err) begin
        if (eq.size() > 0) chk("cfg_err_cycle", cyc, eq.pop_front());
        else chk("unexpected_cfg_err", int'(cfg_err), 0);
      end
      if (de && !prev_de && alq.size() > 0) begin
        int t;
        t = alq.pop_front();
        chk("de_rise_cycle", cyc, t);
        chk("de_rise_screen_x", int'(screen_x), 0);
        chk("line_to_de_gap", cyc - line_cyc, 7);
      end
      if (align_on && pre_x == 0 && !pre_y[CORDW-1]) alq.push_back(cyc + LA);
      if (align_on && prev_hs && !hsync) chk("hsync_start_x", int'(screen_x), -5);
      if (align_on && prev_vs && !vsync) begin
        chk("vsync_start_y", int'(screen_y), -3);
        chk("vsync_start_x", int'(screen_x), -7);
      end
      prev_de = de; prev_hs = hsync; prev_vs = vsync;
    end
  end

  task automatic set_cfg(input cfg_t c);
    cfg_h_res = 15'(c.hr); cfg_h_fp = 15'(c.hf); cfg_h_sync = 15'(c.hs); cfg_h_bp = 15'(c.hb);
    cfg_v_res = 15'(c.vr); cfg_v_fp = 15'(c.vf); cfg_v_sync = 15'(c.vs); cfg_v_bp = 15'(c.vb);
    cfg_h_pol = c.hp; cfg_v_pol = c.vp;
  endtask

  // Holds cfg_valid until a transfer; returns the cycle in which valid && ready was seen
  task automatic offer(input cfg_t c, output int tcyc);
    int n;
    bit got;
    set_cfg(c);
    cfg_valid = 1'b1;
    got = 1'b0;
    n = 0;
    tcyc = -1;
    while (!got && n < 2000) begin
      @(negedge clk_pix);
      if (cfg_ready) begin
        got = 1'b1;
        tcyc = cyc;
      end
      n++;
      @(posedge clk_pix); #1;
    end
    cfg_valid = 1'b0;
    chk("offer_accepted", int'(got), 1);
  endtask

  task automatic wait_pre(input int x, input int y);
    int n;
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < 1000) begin
      @(negedge clk_pix);
      if (pre_x == x && pre_y == y) found = 1'b1;
      n++;
    end
    @(posedge clk_pix); #1;
    chk("wait_pre_found", int'(found), 1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((fq.size() + aq.size() + eq.size()) > 0 && n < budget) begin
      @(negedge clk_pix);
      n++;
    end
    chk(name, fq.size() + aq.size() + eq.size(), 0);
    @(posedge clk_pix); #1;
  endtask

  initial begin
    int t0, t1, t2, t3;
    rst = 1'b1;
    cfg_valid = 1'b0;
    set_cfg(mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    chk("rst_pre_x", int'(pre_x), -7);
    chk("rst_pre_y", int'(pre_y), -4);
    chk("rst_screen_x", int'(screen_x), -7);
    chk("rst_screen_y", int'(screen_y), -4);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_de", int'(de), 0);
    chk("rst_frame", int'(frame), 0);
    chk("rst_line", int'(line), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_mode_applied", int'(mode_applied), 0);

    // Default mode, look-ahead alignment
    @(posedge clk_pix); #1;
    rst = 1'b0;
    align_on = 1'b1;
    @(negedge clk_pix);
    chk("first_pre_x", int'(pre_x), -7);
    fq.push_back(FA); fq.push_back(FA);
    drain("drain_default_mode", 1500);
    align_on = 1'b0;

    // Mid-frame switch to B, with C held back-to-back behind it
    fq.push_back(FA); fq.push_back(FB); fq.push_back(FC); fq.push_back(FC);
    aq.push_back(ap(-6, -4)); aq.push_back(ap(-3, -3));
    wait_pre(0, 1);
    offer(MB, t0);
    @(negedge clk_pix);
    chk("ready_drop_after_transfer", int'(cfg_ready), 0);
    @(posedge clk_pix); #1;
    offer(MC, t1);
    chk("b2b_transfer_in_apply_cycle", t1, applied_cyc);
    drain("drain_mode_switch", 2000);

    // Invalid mode: zero hsync width
    fq.push_back(FC); fq.push_back(FC);
    offer(MD, t2);
    eq.push_back(t2 + 1);
    @(negedge clk_pix);
    chk("ready_after_invalid", int'(cfg_ready), 1);
    @(posedge clk_pix); #1;
    drain("drain_invalid", 1000);

    // Reset while a mode is pending
    wait_pre(0, 0);
    offer(MB, t3);
    @(negedge clk_pix);
    chk("ready_pending_before_rst", int'(cfg_ready), 0);
    repeat (2) @(posedge clk_pix);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    chk("rst2_pre_x", int'(pre_x), -7);
    chk("rst2_pre_y", int'(pre_y), -4);
    chk("rst2_screen_x", int'(screen_x), -7);
    chk("rst2_hsync", int'(hsync), 1);
    @(posedge clk_pix); #1;
    rst = 1'b0;
    fq.push_back(FA); fq.push_back(FA);
    @(negedge clk_pix);
    chk("rst2_cfg_ready", int'(cfg_ready), 1);
    drain("drain_after_rst", 1500);

    repeat (20) @(posedge clk_pix);
    chk("leftover_expectations", fq.size() + aq.size() + eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
